// File: rtl/game_sequencer_pkg.sv
// Shared definitions for the rally controller: phase encodings, field widths, BCD helper.
package game_sequencer_pkg;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LIVES_W = 4;
    localparam int unsigned SCORE_W = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = 8'h99;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Two-digit BCD increment that holds at 99.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] s);
        logic [SCORE_W-1:0] r;
        if (s >= SCORE_MAX) begin
            r = SCORE_MAX;
        end else if (s[3:0] == 4'd9) begin
            r = {4'(s[7:4] + 4'd1), 4'd0};
        end else begin
            r = {s[7:4], 4'(s[3:0] + 4'd1)};
        end
        return r;
    endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Frame down-counter shared by the serve and miss pauses; expires on the tick seen at 1.
module game_sequencer_frame_timer
    import game_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_tick,
    output logic             o_expire_c
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // A load in the same clock as a tick wins; the tick is not counted.
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_tick && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign o_expire_c = i_tick && (count_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Rally controller: sequences serve/play/miss/game-over, keeps BCD score and lives.
module game_sequencer
    import game_sequencer_pkg::*;
#(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned MISS_FRAMES  = 90,
    parameter int unsigned MAX_LIVES    = 3
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_VReset,
    input  logic               i_Button,
    input  logic               i_Hit,
    input  logic               i_Miss,
    output logic               o_BallEnable,
    output logic               o_Recenter,
    output logic [SCORE_W-1:0] o_Score,
    output logic [LIVES_W-1:0] o_Lives,
    output logic               o_GameOver
);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               hit_latch_q, hit_latch_d;
    logic               button_prev_q, button_prev_d;
    logic               press_q, press_d;
    logic               recenter_q, recenter_d;
    logic               ball_enable_q, ball_enable_d;
    logic               game_over_q, game_over_d;

    logic               load_c;
    logic [CNT_W-1:0]   load_val_c;
    logic               tick_c;
    logic               expire_c;
    logic               score_hit_c;

    assign tick_c = i_VReset && ((state_q == ST_SERVE) || (state_q == ST_MISS));

    game_sequencer_frame_timer u_frame_timer (
        .clk        (i_Clk),
        .rst        (i_Reset),
        .i_load     (load_c),
        .i_load_val (load_val_c),
        .i_tick     (tick_c),
        .o_expire_c (expire_c)
    );

    // Next-state, score/lives update and registered-output decode.
    always_comb begin
        state_d       = state_q;
        score_d       = score_q;
        lives_d       = lives_q;
        hit_latch_d   = hit_latch_q;
        recenter_d    = 1'b0;
        load_c        = 1'b0;
        load_val_c    = CNT_W'(SERVE_FRAMES);
        score_hit_c   = 1'b0;
        button_prev_d = i_Button;
        press_d       = i_Button && !button_prev_q;

        case (state_q)
            ST_IDLE: begin
                if (press_q) begin
                    state_d    = ST_SERVE;
                    load_c     = 1'b1;
                    recenter_d = 1'b1;
                end
            end
            ST_SERVE: begin
                if (expire_c) begin
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (i_Miss) begin
                    lives_d = (lives_q != '0) ? lives_q - LIVES_W'(1) : '0;
                    if (lives_d == '0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d    = ST_MISS;
                        load_c     = 1'b1;
                        load_val_c = CNT_W'(MISS_FRAMES);
                    end
                end else if (i_Hit && (!hit_latch_q || i_VReset)) begin
                    score_d     = bcd_inc(score_q);
                    score_hit_c = 1'b1;
                end
            end
            ST_MISS: begin
                if (expire_c) begin
                    state_d    = ST_SERVE;
                    load_c     = 1'b1;
                    recenter_d = 1'b1;
                end
            end
            ST_OVER: begin
                if (press_q) begin
                    score_d    = '0;
                    lives_d    = LIVES_W'(MAX_LIVES);
                    state_d    = ST_SERVE;
                    load_c     = 1'b1;
                    recenter_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame tick re-arms the latch; a hit on the tick clock opens the new frame.
        if (i_VReset) begin
            hit_latch_d = score_hit_c;
        end else if (score_hit_c) begin
            hit_latch_d = 1'b1;
        end

        ball_enable_d = (state_q == ST_PLAY) && (state_d == ST_PLAY);
        game_over_d   = (state_d == ST_OVER);
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q       <= ST_IDLE;
            score_q       <= '0;
            lives_q       <= LIVES_W'(MAX_LIVES);
            hit_latch_q   <= 1'b0;
            button_prev_q <= 1'b0;
            press_q       <= 1'b0;
            recenter_q    <= 1'b0;
            ball_enable_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_q       <= score_d;
            lives_q       <= lives_d;
            hit_latch_q   <= hit_latch_d;
            button_prev_q <= button_prev_d;
            press_q       <= press_d;
            recenter_q    <= recenter_d;
            ball_enable_q <= ball_enable_d;
            game_over_q   <= game_over_d;
        end
    end

    assign o_BallEnable = ball_enable_q;
    assign o_Recenter   = recenter_q;
    assign o_Score      = score_q;
    assign o_Lives      = lives_q;
    assign o_GameOver   = game_over_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized frame-level bench for game_sequencer against a phase/score/lives reference model.
module tb_game_sequencer;

    localparam int SERVE_F = 60;
    localparam int MISS_F  = 90;
    localparam int MAX_L   = 3;
    localparam int FL      = 48;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       vreset = 1'b0;
    logic       button = 1'b0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       ball_en;
    logic       recenter;
    logic [7:0] score;
    logic [3:0] lives;
    logic       game_over;

    always #5 clk = ~clk;

    game_sequencer #(
        .SERVE_FRAMES (SERVE_F),
        .MISS_FRAMES  (MISS_F),
        .MAX_LIVES    (MAX_L)
    ) dut (
        .i_Clk        (clk),
        .i_Reset      (rst),
        .i_VReset     (vreset),
        .i_Button     (button),
        .i_Hit        (hit),
        .i_Miss       (miss),
        .o_BallEnable (ball_en),
        .o_Recenter   (recenter),
        .o_Score      (score),
        .o_Lives      (lives),
        .o_GameOver   (game_over)
    );

    typedef enum int {M_IDLE, M_SERVE, M_PLAY, M_MISS, M_OVER} phase_e;

    phase_e m_phase;
    int     m_rem;
    int     m_score;
    int     m_lives;
    int     n_checks = 0;
    int     n_pass   = 0;
    int     frame_no = 0;
    bit     hit_pat [FL];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s (frame %0d): got %0d expected %0d", tag, frame_no, got, exp);
    endtask

    function automatic int to_bcd(input int n);
        return ((n / 10) * 16) + (n % 10);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_phase = M_IDLE;
        m_rem   = 0;
        m_score = 0;
        m_lives = MAX_L;
    endtask

    task automatic check_reset_outputs(input string where);
        check_eq({where, " ball_en"}, int'(ball_en), 0);
        check_eq({where, " recenter"}, int'(recenter), 0);
        check_eq({where, " score"}, int'(score), 0);
        check_eq({where, " lives"}, int'(lives), MAX_L);
        check_eq({where, " game_over"}, int'(game_over), 0);
    endtask

    // One frame: tick on cycle 0, hits from hit_pat, optional press/miss/reset cycle.
    task automatic do_frame(input int press_at, input int miss_at, input int rst_at);
        int exp_rc_cyc, exp_rc_cnt, got_rc_cyc, got_rc_cnt, first_hit;
        bit was_play, exp_ben1, got_ben1;
        frame_no++;
        exp_rc_cyc = -1;
        exp_rc_cnt = 0;
        if (m_phase == M_SERVE || m_phase == M_MISS) begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_phase == M_SERVE) begin
                    m_phase = M_PLAY;
                end else begin
                    m_phase    = M_SERVE;
                    m_rem      = SERVE_F;
                    exp_rc_cyc = 0;
                    exp_rc_cnt = 1;
                end
            end
        end
        was_play  = (m_phase == M_PLAY);
        exp_ben1  = was_play && (miss_at != 1);
        first_hit = -1;
        for (int i = FL - 1; i >= 0; i--) if (hit_pat[i]) first_hit = i;
        if (rst_at < 0) begin
            if (press_at >= 0 && (m_phase == M_IDLE || m_phase == M_OVER)) begin
                if (m_phase == M_OVER) begin
                    m_score = 0;
                    m_lives = MAX_L;
                end
                m_phase    = M_SERVE;
                m_rem      = SERVE_F;
                exp_rc_cyc = press_at + 1;
                exp_rc_cnt++;
            end else if (was_play) begin
                if (first_hit >= 0 && (miss_at < 0 || first_hit < miss_at) && m_score < 99)
                    m_score++;
                if (miss_at >= 0) begin
                    m_lives--;
                    if (m_lives == 0) m_phase = M_OVER;
                    else begin
                        m_phase = M_MISS;
                        m_rem   = MISS_F;
                    end
                end
            end
        end

        got_rc_cyc = -1;
        got_rc_cnt = 0;
        got_ben1   = 1'b0;
        for (int i = 0; i < FL; i++) begin
            vreset = (i == 0);
            button = (press_at >= 0) && (i >= press_at);
            hit    = hit_pat[i];
            miss   = (i == miss_at);
            rst    = (i == rst_at);
            step();
            if (recenter) begin
                got_rc_cnt++;
                if (got_rc_cyc < 0) got_rc_cyc = i;
            end
            if (i == 1) got_ben1 = ball_en;
            if (i == rst_at) check_reset_outputs("mid-reset");
        end
        {vreset, button, hit, miss, rst} = '0;
        if (rst_at >= 0) model_reset();

        check_eq("score", int'(score), to_bcd(m_score));
        check_eq("lives", int'(lives), m_lives);
        check_eq("game_over", int'(game_over), int'(m_phase == M_OVER));
        check_eq("ball_en end", int'(ball_en), int'(m_phase == M_PLAY));
        check_eq("ball_en cyc1", int'(got_ben1), int'(exp_ben1));
        check_eq("recenter count", got_rc_cnt, exp_rc_cnt);
        check_eq("recenter cycle", got_rc_cyc, exp_rc_cyc);
    endtask

    task automatic clear_hits();
        foreach (hit_pat[i]) hit_pat[i] = 1'b0;
    endtask

    task automatic rand_hits(input int pct);
        int s, l;
        clear_hits();
        if (int'($urandom_range(99, 0)) < pct) begin
            s = int'($urandom_range(30, 1));
            l = int'($urandom_range(12, 1));
            for (int i = s; i < s + l && i < FL; i++) hit_pat[i] = 1'b1;
            if ($urandom_range(1, 0) == 1) begin
                s = s + l + int'($urandom_range(4, 1));
                for (int i = s; i < s + 5 && i < FL; i++) hit_pat[i] = 1'b1;
            end
        end
    endtask

    task automatic rand_frame(input int hit_pct, input int miss_pct, input int press_pct);
        int p, m;
        rand_hits(hit_pct);
        m = (int'($urandom_range(99, 0)) < miss_pct) ? int'($urandom_range(FL - 1, 1)) : -1;
        p = (int'($urandom_range(99, 0)) < press_pct) ? int'($urandom_range(20, 2)) : -1;
        do_frame(p, m, -1);
    endtask

    task automatic wait_play(input int budget);
        int n;
        n = 0;
        while (m_phase != M_PLAY && n < budget) begin
            rand_frame(40, 0, (m_phase == M_IDLE || m_phase == M_OVER) ? 100 : 30);
            n++;
        end
        check_eq("reach PLAY within budget", int'(m_phase == M_PLAY), 1);
    endtask

    initial begin
        int n;
        model_reset();
        clear_hits();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset_outputs("power-on");

        // Serve: recenter on press, ball released after exactly SERVE_F ticks.
        do_frame(3, -1, -1);
        for (int f = 0; f < SERVE_F; f++) do_frame(-1, -1, -1);

        // Long multi-burst hit: one point per frame.
        for (int r = 0; r < 2; r++) begin
            clear_hits();
            for (int i = 2; i < 16; i++) hit_pat[i] = 1'b1;
            for (int i = 18; i < 31; i++) hit_pat[i] = 1'b1;
            for (int i = 33; i < 46; i++) hit_pat[i] = 1'b1;
            do_frame(-1, -1, -1);
        end

        // Climb through BCD carries to saturation.
        n = 0;
        while (m_score < 99 && n < 120) begin
            rand_hits(100);
            hit_pat[5] = 1'b1;
            do_frame((n % 3 == 0) ? 7 : -1, -1, -1);
            n++;
        end
        check_eq("score reached 99", m_score, 99);
        for (int f = 0; f < 3; f++) begin
            rand_hits(100);
            hit_pat[9] = 1'b1;
            do_frame(-1, -1, -1);
        end

        // Hit and miss on the same clock: miss wins.
        clear_hits();
        hit_pat[20] = 1'b1;
        hit_pat[21] = 1'b1;
        do_frame(-1, 20, -1);

        // Remaining lives lost after each serve, down to game over.
        n = 0;
        while (m_phase != M_OVER && n < 4) begin
            wait_play(200);
            rand_hits(50);
            do_frame(-1, int'($urandom_range(40, 1)), -1);
            n++;
        end
        check_eq("game over reached", int'(m_phase == M_OVER), 1);
        for (int f = 0; f < 2; f++) rand_frame(80, 50, 0);
        clear_hits();
        do_frame(4, -1, -1);

        // Reset mid-serve and mid-play.
        for (int f = 0; f < 5; f++) rand_frame(50, 30, 30);
        clear_hits();
        do_frame(-1, -1, 20);
        wait_play(100);
        for (int f = 0; f < 3; f++) rand_frame(100, 0, 0);
        clear_hits();
        hit_pat[10] = 1'b1;
        do_frame(-1, -1, 30);

        // Free-running random play.
        for (int f = 0; f < 250; f++) rand_frame(50, 8, 30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
